// File: rtl/imem_loader.sv
// imem_loader: receives a byte-stream program image (16-bit little-endian word
// count followed by little-endian 32-bit words) and writes it into instruction
// memory from address 0. The processor is held in reset until a load succeeds.
module imem_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int          DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [16:0] DEPTH_17 = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           word_q, word_d;

  logic                  rx_ready_q, rx_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic [15:0]           hdr_full;
  logic [15:0]           idx_ext;

  // A byte moves only when the registered ready and the sender's valid coincide.
  assign accept   = rx_valid & rx_ready_q;
  assign hdr_full = {rx_data, count_q[7:0]};
  assign idx_ext  = 16'(idx_q);

  // Next-state and next-output logic; outputs are derived from the next state
  // so that every output is a flop aligned with the state it belongs to.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    error_d      = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_HDR_LO;
          error_d     = 1'b0;
          cpu_reset_d = 1'b1;
          idx_d       = '0;
          byte_cnt_d  = '0;
          count_d     = '0;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          count_d[7:0] = rx_data;
          state_d      = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          count_d = hdr_full;
          if (hdr_full == 16'd0 || {1'b0, hdr_full} > DEPTH_17) begin
            state_d = S_ERR;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: word_d[7:0]   = rx_data;
            2'd1: word_d[15:8]  = rx_data;
            2'd2: word_d[23:16] = rx_data;
            default: begin
              state_d      = S_WRITE;
              imem_we_d    = 1'b1;
              imem_addr_d  = idx_q;
              imem_wdata_d = {rx_data, word_q};
            end
          endcase
        end
      end
      S_WRITE: begin
        // The index is compared before incrementing, so a full-depth load
        // finishes at DEPTH-1 without the index ever wrapping.
        if (idx_ext == count_q - 16'd1) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_COLLECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d == S_HDR_LO) || (state_d == S_HDR_HI) || (state_d == S_COLLECT);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    if (state_d == S_DONE) begin
      cpu_reset_d = 1'b0;
    end
    if (state_d == S_ERR) begin
      error_d = 1'b1;
    end
  end

  // State and output registers; reset releases the bus and holds the CPU in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized program loads against a
// byte-list reference model of the loader's image format.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int AW    = 6;
  localparam int DEPTH = 2 ** AW;

  logic          clk;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observation log filled by the monitor, read only by the stimulus block
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            done_cnt         = 0;
  int            done_cpu_rst_hi  = 0;
  int            done_prev_low    = 0;
  int            we_ready_overlap = 0;
  logic          prev_cpu_reset   = 1'b1;

  // Reference-model inputs and outputs
  logic [7:0]  stim[$];
  logic [31:0] exp_words[$];
  bit          exp_err;
  int          exp_n;
  int          wr_base;
  int          done_base;

  // Records every memory write and done pulse, sampled midway through the cycle
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      if (rx_ready) we_ready_overlap++;
    end
    if (done) begin
      done_cnt++;
      if (cpu_reset) done_cpu_rst_hi++;
      if (!prev_cpu_reset) done_prev_low++;
    end
    prev_cpu_reset = cpu_reset;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: image = count (LE16), then count little-endian words
  task automatic build_expect();
    exp_words.delete();
    exp_n   = int'(stim[0]) + (int'(stim[1]) << 8);
    exp_err = (exp_n == 0) || (exp_n > DEPTH);
    if (!exp_err) begin
      for (int i = 0; i < exp_n; i++) begin
        exp_words.push_back({stim[5 + 4*i], stim[4 + 4*i], stim[3 + 4*i], stim[2 + 4*i]});
      end
    end
  endtask

  task automatic make_random(input int n, input int data_words);
    stim.delete();
    stim.push_back(n[7:0]);
    stim.push_back(n[15:8]);
    for (int i = 0; i < 4 * data_words; i++) stim.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic make_scenario1();
    logic [7:0] img[10] = '{8'h02, 8'h00, 8'h05, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h80, 8'hE2};
    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(img[i]);
  endtask

  // Presents one byte and returns 1ns after the edge that accepts it
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    int cyc = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!ok && cyc < 100) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
      cyc++;
    end
    check("byte_accept_timeout", 32'(ok), 32'd1);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic feed(input int from, input int to, input int gap);
    for (int i = from; i < to; i++) send_byte(stim[i], gap);
  endtask

  task automatic applyStimulus();
    build_expect();
    wr_base   = wr_addr_q.size();
    done_base = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_cpu_reset", 32'(cpu_reset), 32'd1);
    check("start_error_clear", 32'(error), 32'd0);
  endtask

  task automatic checkOutput(input string tag);
    bit idle = 0;
    int cyc  = 0;
    rx_valid = 1'b0;
    while (!idle && cyc < 2000) begin
      @(negedge clk);
      if (!busy) idle = 1;
      cyc++;
    end
    check({tag, "_idle_timeout"}, 32'(idle), 32'd1);
    check({tag, "_write_count"}, 32'(wr_addr_q.size() - wr_base), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && wr_base + i < wr_addr_q.size(); i++) begin
      check({tag, "_addr"}, 32'(wr_addr_q[wr_base + i]), 32'(i));
      check({tag, "_data"}, wr_data_q[wr_base + i], exp_words[i]);
    end
    check({tag, "_done_pulses"}, 32'(done_cnt - done_base), exp_err ? 32'd0 : 32'd1);
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(exp_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_low"}, 32'(done), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Full load from the current stimulus; error images send only their header
  task automatic run_load(input string tag, input int gap);
    applyStimulus();
    if (exp_err) begin
      feed(0, 2, 0);
      @(negedge clk);
      check({tag, "_err_state_error"}, 32'(error), 32'd1);
      check({tag, "_err_state_busy"}, 32'(busy), 32'd1);
      check({tag, "_err_state_no_we"}, 32'(imem_we), 32'd0);
    end else begin
      feed(0, stim.size(), gap);
    end
    checkOutput(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
  endtask

  // Directed scenarios followed by randomized loads
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_cpu_reset_held", 32'(cpu_reset), 32'd1);

    $display("[TB] scenario 1: two-word load, valid held high");
    make_scenario1();
    run_load("s1", 0);
    check("s1_word0_literal", exp_words[0], 32'hE3A00005);
    check("s1_cpu_reset_high_before_done", 32'(done_prev_low), 32'd0);
    check("s1_cpu_reset_low_in_done", 32'(done_cpu_rst_hi), 32'd0);

    $display("[TB] scenario 2: zero word count");
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h00);
    run_load("s2", 0);
    repeat (3) @(posedge clk);
    #1;
    check("s2_error_sticky", 32'(error), 32'd1);

    $display("[TB] scenario 3: oversize and full-depth loads");
    make_random(DEPTH + 1, 0);
    run_load("s3_over", 0);
    make_random(DEPTH, DEPTH);
    run_load("s3_full", 0);
    check("s3_last_addr", 32'(wr_addr_q[wr_addr_q.size() - 1]), 32'(DEPTH - 1));

    $display("[TB] scenario 4: gaps of 3 idle cycles between bytes");
    make_scenario1();
    run_load("s4", 3);

    $display("[TB] scenario 5: reset after 6 bytes, then reload");
    make_scenario1();
    applyStimulus();
    feed(0, 6, 0);
    rx_valid = 1'b0;
    @(negedge clk);
    check("s5_write_cycle", 32'(imem_we), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_reset_values("s5_reset");
    @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("s5_one_write", 32'(wr_addr_q.size() - wr_base), 32'd1);
    check("s5_addr0", 32'(wr_addr_q[wr_base]), 32'd0);
    check("s5_data0", wr_data_q[wr_base], exp_words[0]);
    check("s5_still_idle", 32'(busy), 32'd0);
    run_load("s5_reload", 1);

    $display("[TB] scenario 6: start ignored mid-load, restart after done");
    make_scenario1();
    applyStimulus();
    feed(0, 3, 0);
    rx_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    feed(3, stim.size(), 0);
    checkOutput("s6");
    make_random(3, 3);
    run_load("s6_restart", 0);

    $display("[TB] randomized loads");
    for (int r = 0; r < 12; r++) begin
      int n = (r % 4 == 3) ? int'($urandom_range(DEPTH + 1, 300)) : int'($urandom_range(1, 6));
      make_random(n, (n > DEPTH) ? 0 : n);
      run_load("rand", int'($urandom_range(0, 2)));
    end

    check("no_ready_during_write", 32'(we_ready_overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
